// File: rtl/ir_nec_decoder_pkg.sv
// Shared constants, FSM encoding and pulse-width window helper for the NEC IR decoder.
package ir_nec_decoder_pkg;

  localparam int unsigned N_LEAD_MARK  = 16;
  localparam int unsigned N_LEAD_SPACE = 8;
  localparam int unsigned N_RPT_SPACE  = 4;
  localparam int unsigned N_ONE_SPACE  = 3;
  localparam int unsigned N_UNIT       = 1;
  localparam int unsigned TO_UNITS_DEF = 20;

  localparam int WIDTH_W = 20;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_RPT_STOP   = 3'd6,
    ST_CHECK      = 3'd7
  } state_t;

  // True when w is within n units +/- (n units / tol_div), bounds inclusive.
  // Written as w + tol >= target so the lower bound never underflows.
  function automatic logic in_window(input logic [WIDTH_W-1:0] w,
                                     input int unsigned n,
                                     input int unsigned unit_cyc,
                                     input int unsigned tol_div);
    int unsigned target;
    int unsigned tol;
    int unsigned wl;
    target = n * unit_cyc;
    tol    = target / tol_div;
    wl     = 32'(w);
    return (wl + tol >= target) && (wl <= target + tol);
  endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Signal bundle between the NEC decoder (master) and its consumer (slave).
interface ir_nec_decoder_if;
  import ir_nec_decoder_pkg::*;

  // No backpressure: code_valid / code_rpt / code_err are single-cycle strobes
  // that the consumer must sample in the cycle they are high; ir_code holds.
  logic        ir_rx;
  logic [15:0] ir_code;
  logic        code_valid;
  logic        code_rpt;
  logic        code_err;
  logic        busy;
  state_t      state;

  modport master (
    input  ir_rx,
    output ir_code, code_valid, code_rpt, code_err, busy, state
  );

  modport slave (
    output ir_rx,
    input  ir_code, code_valid, code_rpt, code_err, busy, state
  );

endinterface

// File: rtl/ir_sync_edge.sv
// 2-FF synchronizer with rise/fall strobes on the synchronized level.
module ir_sync_edge #(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] fill;
  logic       primed;

  // Edges are suppressed until all three stages hold post-reset samples,
  // so a line already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= IDLE_LVL;
      s2   <= IDLE_LVL;
      s3   <= IDLE_LVL;
      fill <= 2'd0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign primed = (fill == 2'd3);
  assign rise   = primed &  s2 & ~s3;
  assign fall   = primed & ~s2 &  s3;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: measures mark/space widths between edges and walks the frame FSM.
module ir_nec_decoder
  import ir_nec_decoder_pkg::*;
#(
  parameter int unsigned UNIT_CYC = 28125,
  parameter int unsigned TOL_DIV  = 4,
  parameter int unsigned TO_UNITS = TO_UNITS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  ir_nec_decoder_if.master bus
);

  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
  localparam logic [WIDTH_W-1:0] TO_LIM    = WIDTH_W'(TO_UNITS * UNIT_CYC);

  logic               rise;
  logic               fall;
  state_t             state;
  logic [WIDTH_W-1:0] width;
  logic [31:0]        sr;
  logic [4:0]         bit_cnt;
  logic [15:0]        ir_code;
  logic               code_valid;
  logic               code_rpt;
  logic               code_err;
  logic               timeout;
  logic               m16, m8, m4, m3, m1;

  ir_sync_edge #(.IDLE_LVL(1'b1)) u_sync (
    .clk  (clock),
    .rst  (reset),
    .din  (bus.ir_rx),
    .rise (rise),
    .fall (fall)
  );

  assign m16     = in_window(width, N_LEAD_MARK,  UNIT_CYC, TOL_DIV);
  assign m8      = in_window(width, N_LEAD_SPACE, UNIT_CYC, TOL_DIV);
  assign m4      = in_window(width, N_RPT_SPACE,  UNIT_CYC, TOL_DIV);
  assign m3      = in_window(width, N_ONE_SPACE,  UNIT_CYC, TOL_DIV);
  assign m1      = in_window(width, N_UNIT,       UNIT_CYC, TOL_DIV);
  assign timeout = (state != ST_IDLE) && (width > TO_LIM);

  // width reloads to 1 on an edge so at the next edge it equals the phase length.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      width      <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      ir_code    <= '0;
      code_valid <= 1'b0;
      code_rpt   <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      code_rpt   <= 1'b0;
      code_err   <= 1'b0;

      if (rise || fall)          width <= WIDTH_W'(1);
      else if (width != WIDTH_MAX) width <= width + 1'b1;

      if (timeout) begin
        state    <= ST_IDLE;
        code_err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (fall) state <= ST_LEAD_MARK;

          ST_LEAD_MARK: if (rise) begin
            if (m16) state <= ST_LEAD_SPACE;
            else begin state <= ST_IDLE; code_err <= 1'b1; end
          end

          ST_LEAD_SPACE: if (fall) begin
            if (m8) begin
              state   <= ST_BIT_MARK;
              bit_cnt <= '0;
            end else if (m4) begin
              state <= ST_RPT_STOP;
            end else begin
              state    <= ST_IDLE;
              code_err <= 1'b1;
            end
          end

          ST_BIT_MARK: if (rise) begin
            if (m1) state <= ST_BIT_SPACE;
            else begin state <= ST_IDLE; code_err <= 1'b1; end
          end

          // LSB first: each new bit enters at the top and shifts down.
          ST_BIT_SPACE: if (fall) begin
            if (m1 || m3) begin
              sr      <= {m3, sr[31:1]};
              bit_cnt <= bit_cnt + 5'd1;
              state   <= (bit_cnt == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
            end else begin
              state    <= ST_IDLE;
              code_err <= 1'b1;
            end
          end

          ST_STOP_MARK: if (rise) begin
            if (m1) state <= ST_CHECK;
            else begin state <= ST_IDLE; code_err <= 1'b1; end
          end

          ST_RPT_STOP: if (rise) begin
            state <= ST_IDLE;
            if (m1) code_rpt <= 1'b1;
            else    code_err <= 1'b1;
          end

          ST_CHECK: begin
            state <= ST_IDLE;
            if ((sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16])) begin
              ir_code    <= {sr[7:0], sr[23:16]};
              code_valid <= 1'b1;
            end else begin
              code_err <= 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ir_code    = ir_code;
  assign bus.code_valid = code_valid;
  assign bus.code_rpt   = code_rpt;
  assign bus.code_err   = code_err;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.state      = state;

endmodule
